// File: rtl/pwr_seq_ctrl_if.sv
// Request and status bundle between the pattern/button controller and the panel power sequencer.
// Requests are single-cycle pulses sampled on the rising clk edge with no ready/ack; a pulse that is not acted on is dropped.
interface pwr_seq_ctrl_if;
    logic       pwr_on_req;
    logic       pwr_off_req;
    logic       fault;
    logic       clr_fault;
    logic       en_p14v;
    logic       en_n14v;
    logic       en_gvddp;
    logic       en_gvddn;
    logic       en_vgh;
    logic       en_vgl;
    logic [5:0] mux_en;
    logic       busy;
    logic       pwr_good;
    logic       seq_done;
    logic       fault_latched;
    logic [3:0] state_dbg;

    modport master (
        output pwr_on_req, pwr_off_req, fault, clr_fault,
        input  en_p14v, en_n14v, en_gvddp, en_gvddn, en_vgh, en_vgl,
        input  mux_en, busy, pwr_good, seq_done, fault_latched, state_dbg
    );

    modport slave (
        input  pwr_on_req, pwr_off_req, fault, clr_fault,
        output en_p14v, en_n14v, en_gvddp, en_gvddn, en_vgh, en_vgl,
        output mux_en, busy, pwr_good, seq_done, fault_latched, state_dbg
    );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Panel power sequencer: rails on in fixed order with ms dwells, reverse-order power-down,
// latched fault shutdown. All outputs are registered decodes of the next state.
module pwr_seq_ctrl #(
    parameter int CLK_PER_MS = 81000,
    parameter int T_RAIL_MS  = 5,
    parameter int T_GVDD_MS  = 5,
    parameter int T_GATE_MS  = 10,
    parameter int T_OFF_MS   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pwr_seq_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        S_OFF, S_ON_RAIL, S_ON_GVDD, S_ON_GATE, S_ON,
        S_OFF_MUX, S_OFF_GATE, S_OFF_GVDD, S_OFF_RAIL, S_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [16:0] pre_cnt;
    logic [15:0] ms_cnt;
    logic [15:0] dwell_ms;
    logic        tick, dwell_done;
    logic        rail_on, gvdd_on, gate_on, mux_on;
    logic        busy_nxt, good_nxt, done_nxt, flt_nxt;

    always_comb begin
        dwell_ms = '0;
        unique case (state)
            S_ON_RAIL: dwell_ms = 16'(T_RAIL_MS);
            S_ON_GVDD: dwell_ms = 16'(T_GVDD_MS);
            S_ON_GATE: dwell_ms = 16'(T_GATE_MS);
            S_OFF_MUX, S_OFF_GATE, S_OFF_GVDD, S_OFF_RAIL: dwell_ms = 16'(T_OFF_MS);
            default: dwell_ms = '0;
        endcase
    end

    // A zero dwell still costs one cycle; otherwise expire on the tick that makes ms_cnt reach T.
    assign tick       = (pre_cnt == 17'(CLK_PER_MS - 1));
    assign dwell_done = (dwell_ms == '0) || (tick && (ms_cnt == dwell_ms - 16'd1));

    always_comb begin
        state_nxt = state;
        if (bus.fault) begin
            state_nxt = S_FAULT;
        end else begin
            unique case (state)
                S_OFF:      if (bus.pwr_on_req && !bus.pwr_off_req) state_nxt = S_ON_RAIL;
                S_ON_RAIL:  if (bus.pwr_off_req) state_nxt = S_OFF_RAIL;
                            else if (dwell_done) state_nxt = S_ON_GVDD;
                S_ON_GVDD:  if (bus.pwr_off_req) state_nxt = S_OFF_GVDD;
                            else if (dwell_done) state_nxt = S_ON_GATE;
                S_ON_GATE:  if (bus.pwr_off_req) state_nxt = S_OFF_GATE;
                            else if (dwell_done) state_nxt = S_ON;
                S_ON:       if (bus.pwr_off_req) state_nxt = S_OFF_MUX;
                S_OFF_MUX:  if (dwell_done) state_nxt = S_OFF_GATE;
                S_OFF_GATE: if (dwell_done) state_nxt = S_OFF_GVDD;
                S_OFF_GVDD: if (dwell_done) state_nxt = S_OFF_RAIL;
                S_OFF_RAIL: if (dwell_done) state_nxt = S_OFF;
                S_FAULT:    if (bus.clr_fault) state_nxt = S_OFF;
                default:    state_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        rail_on  = state_nxt inside {S_ON_RAIL, S_ON_GVDD, S_ON_GATE, S_ON,
                                     S_OFF_MUX, S_OFF_GATE, S_OFF_GVDD};
        gvdd_on  = state_nxt inside {S_ON_GVDD, S_ON_GATE, S_ON, S_OFF_MUX, S_OFF_GATE};
        gate_on  = state_nxt inside {S_ON_GATE, S_ON, S_OFF_MUX};
        mux_on   = (state_nxt == S_ON);
        busy_nxt = !(state_nxt inside {S_OFF, S_ON, S_FAULT});
        good_nxt = (state_nxt == S_ON);
        flt_nxt  = (state_nxt == S_FAULT);
        // Only completed sequences pulse; leaving FAULT is not one.
        done_nxt = ((state_nxt == S_ON) && (state != S_ON)) ||
                   ((state_nxt == S_OFF) && (state == S_OFF_RAIL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OFF;
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                pre_cnt <= '0;
                ms_cnt  <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                ms_cnt  <= ms_cnt + 16'd1;
            end else begin
                pre_cnt <= pre_cnt + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.en_p14v       <= 1'b1;
            bus.en_n14v       <= 1'b1;
            bus.en_gvddp      <= 1'b1;
            bus.en_gvddn      <= 1'b1;
            bus.en_vgh        <= 1'b1;
            bus.en_vgl        <= 1'b1;
            bus.mux_en        <= 6'h00;
            bus.busy          <= 1'b0;
            bus.pwr_good      <= 1'b0;
            bus.seq_done      <= 1'b0;
            bus.fault_latched <= 1'b0;
        end else begin
            bus.en_p14v       <= !rail_on;
            bus.en_n14v       <= !rail_on;
            bus.en_gvddp      <= !gvdd_on;
            bus.en_gvddn      <= !gvdd_on;
            bus.en_vgh        <= !gate_on;
            bus.en_vgl        <= !gate_on;
            bus.mux_en        <= mux_on ? 6'h3F : 6'h00;
            bus.busy          <= busy_nxt;
            bus.pwr_good      <= good_nxt;
            bus.seq_done      <= done_nxt;
            bus.fault_latched <= flt_nxt;
        end
    end

    assign bus.state_dbg = state;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed and randomized bench for pwr_seq_ctrl with a level/direction/countdown reference model.
module tb_pwr_seq_ctrl;

    localparam int CPM    = 4;
    localparam int T_RAIL = 2;
    localparam int T_GVDD = 1;
    localparam int T_GATE = 3;
    localparam int T_OFF  = 1;
    localparam logic [15:0] RST_VEC = 16'hFC00;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pwr_seq_ctrl_if bus ();

    pwr_seq_ctrl #(
        .CLK_PER_MS(CPM), .T_RAIL_MS(T_RAIL), .T_GVDD_MS(T_GVDD),
        .T_GATE_MS(T_GATE), .T_OFF_MS(T_OFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_lvl = number of groups enabled (rail, gvdd, gate, mux), m_dir = +1 up / -1 down / 0 idle.
    int m_lvl, m_dir, m_rem;
    bit m_flt, m_done;

    function automatic int dwell(input int t);
        return (t == 0) ? 1 : t * CPM;
    endfunction

    function automatic int up_ms(input int lvl);
        case (lvl)
            1:       return T_RAIL;
            2:       return T_GVDD;
            default: return T_GATE;
        endcase
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_dir = 0; m_rem = 0; m_flt = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit on, input bit off, input bit f, input bit clr);
        m_done = 0;
        if (f) begin
            m_flt = 1; m_lvl = 0; m_dir = 0;
        end else if (m_flt) begin
            if (clr) m_flt = 0;
        end else if (m_dir == 0) begin
            if (m_lvl == 0 && on && !off) begin
                m_lvl = 1; m_dir = 1; m_rem = dwell(T_RAIL);
            end else if (m_lvl == 4 && off) begin
                m_lvl = 3; m_dir = -1; m_rem = dwell(T_OFF);
            end
        end else if (m_dir == 1) begin
            if (off) begin
                m_lvl = m_lvl - 1; m_dir = -1; m_rem = dwell(T_OFF);
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_lvl = m_lvl + 1;
                    if (m_lvl == 4) begin
                        m_dir = 0; m_done = 1;
                    end else begin
                        m_rem = dwell(up_ms(m_lvl));
                    end
                end
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                if (m_lvl == 0) begin
                    m_dir = 0; m_done = 1;
                end else begin
                    m_lvl = m_lvl - 1; m_rem = dwell(T_OFF);
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic r, g, t;
        r = (m_lvl >= 1); g = (m_lvl >= 2); t = (m_lvl >= 3);
        return {!r, !r, !g, !g, !t, !t, (m_lvl == 4) ? 6'h3F : 6'h00,
                (m_dir != 0), (m_lvl == 4 && m_dir == 0), m_done, m_flt};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {bus.en_p14v, bus.en_n14v, bus.en_gvddp, bus.en_gvddn, bus.en_vgh, bus.en_vgl,
                bus.mux_en, bus.busy, bus.pwr_good, bus.seq_done, bus.fault_latched};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one edge, advance the model, check 1 time unit later.
    task automatic step(input bit on, input bit off, input bit f, input bit clr);
        bus.pwr_on_req  = on;
        bus.pwr_off_req = off;
        bus.fault       = f;
        bus.clr_fault   = clr;
        @(posedge clk);
        model_edge(on, off, f, clr);
        #1;
        chk("model", obs_vec(), exp_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    int  flt_hold;
    bit  r_on, r_off, r_f, r_clr;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.pwr_on_req = 0; bus.pwr_off_req = 0; bus.fault = 0; bus.clr_fault = 0;
        model_reset();
        #12;
        chk("reset_vals", obs_vec(), RST_VEC);
        rst_n = 1'b1;

        // Power-up timing: rails at edge 1, gvdd at 9, gate at 13, ON at 25
        step(1, 0, 0, 0);
        chk("t1_rail_on", 16'({bus.en_p14v, bus.en_n14v, bus.en_gvddp}), 16'b001);
        idle(7);
        chk("t1_gvdd_wait", 16'(bus.en_gvddp), 16'd1);
        idle(1);
        chk("t1_gvdd_on", 16'({bus.en_gvddp, bus.en_gvddn, bus.en_vgh}), 16'b001);
        idle(3);
        chk("t1_gate_wait", 16'(bus.en_vgh), 16'd1);
        idle(1);
        chk("t1_gate_on", 16'({bus.en_vgh, bus.en_vgl, bus.busy}), 16'b001);
        idle(11);
        chk("t1_on_wait", 16'({bus.mux_en, bus.pwr_good, bus.busy}), 16'b0000001);
        idle(1);
        chk("t1_on", 16'({bus.mux_en, bus.pwr_good, bus.seq_done, bus.busy}), 16'b111111110);
        idle(1);
        chk("t1_done_pulse", 16'({bus.pwr_good, bus.seq_done}), 16'b10);

        // Power-down from ON at 4-cycle spacing
        step(0, 1, 0, 0);
        chk("t2_mux_off", 16'({bus.mux_en, bus.pwr_good, bus.en_vgh, bus.busy}), 16'b000000001);
        idle(4);
        chk("t2_gate_off", 16'({bus.en_vgh, bus.en_gvddp}), 16'b10);
        idle(4);
        chk("t2_gvdd_off", 16'({bus.en_gvddp, bus.en_p14v}), 16'b10);
        idle(4);
        chk("t2_rail_off", 16'({bus.en_p14v, bus.busy, bus.seq_done}), 16'b110);
        idle(4);
        chk("t2_off_done", 16'({bus.busy, bus.seq_done}), 16'b01);

        // Abort during ON_GVDD
        step(1, 0, 0, 0);
        idle(8);
        chk("t3_in_gvdd", 16'(bus.en_gvddp), 16'd0);
        step(0, 1, 0, 0);
        chk("t3_abort", 16'({bus.en_gvddp, bus.en_vgh, bus.en_p14v}), 16'b110);
        idle(3);
        chk("t3_rail_hold", 16'(bus.en_p14v), 16'd0);
        idle(1);
        chk("t3_rail_off", 16'({bus.en_p14v, bus.busy}), 16'b11);
        idle(4);
        chk("t3_off_done", 16'({bus.busy, bus.seq_done}), 16'b01);

        // Simultaneous on/off in OFF; on_req ignored during ON_GATE
        step(1, 1, 0, 0);
        chk("t4_both_req", obs_vec(), RST_VEC);
        step(1, 0, 0, 0);
        idle(12);
        step(1, 0, 0, 0);
        idle(10);
        chk("t4_on_wait", 16'(bus.pwr_good), 16'd0);
        idle(1);
        chk("t4_on_time", 16'({bus.pwr_good, bus.seq_done}), 16'b11);
        step(0, 1, 0, 0);
        idle(16);

        // Fault during ON_GATE
        step(1, 0, 0, 0);
        idle(12);
        step(0, 0, 1, 0);
        chk("t5_fault", obs_vec(), 16'hFC01);
        step(0, 0, 1, 1);
        chk("t5_clr_ignored", obs_vec(), 16'hFC01);
        step(0, 0, 0, 0);
        chk("t5_sticky", 16'(bus.fault_latched), 16'd1);
        step(0, 0, 0, 1);
        chk("t5_cleared", obs_vec(), RST_VEC);

        // Asynchronous reset while ON, then a clean re-sequence
        step(1, 0, 0, 0);
        idle(24);
        chk("t6_on", 16'(bus.pwr_good), 16'd1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_rst", obs_vec(), RST_VEC);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1, 0, 0, 0);
        idle(24);
        chk("t6_reseq", 16'({bus.mux_en, bus.pwr_good, bus.seq_done}), 16'h00FF);

        // Random traffic against the model
        flt_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (flt_hold == 0 && $urandom_range(0, 199) == 0) flt_hold = $urandom_range(1, 4);
            r_f   = (flt_hold != 0);
            if (flt_hold != 0) flt_hold--;
            r_on  = ($urandom_range(0, 3) == 0);
            r_off = ($urandom_range(0, 39) == 0);
            r_clr = ($urandom_range(0, 9) == 0);
            step(r_on, r_off, r_f, r_clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
